strob_seq: RTL and testbench

STROB_SEQ -- requirements
Module: strob_seq

---
 rtl/strob_seq.sv | 154 +++++++++++++++
 tb/tb_strob_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/strob_seq.sv
// strob_seq: processor-cycle strobe sequencer (PC, STROB1, optional WAIT, STROB2, GOT, KC)
// with a memory-answer timeout that raises a sticky alarm instead of hanging.
`default_nettype none

module strob_seq #(
    parameter int T_PULSE = 2,
    parameter int T_GOT   = 1,
    parameter int T_TOUT  = 64
) (
    input  logic       clk,
    input  logic       clm_n,
    input  logic       start,
    input  logic       ekc_1,
    input  logic       ekc_2,
    input  logic       mem,
    input  logic       ok,
    output logic       pc,
    output logic       strob1,
    output logic       strob2,
    output logic       got,
    output logic       kc,
    output logic       busy,
    output logic       alarm,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PC    = 3'd1,
        S1    = 3'd2,
        WAIT  = 3'd3,
        S2    = 3'd4,
        GOT   = 3'd5,
        KC    = 3'd6
    } state_t;

    localparam logic [7:0] LEN_PULSE = 8'(T_PULSE);
    localparam logic [7:0] LEN_GOT   = 8'(T_GOT);
    localparam logic [7:0] LEN_TOUT  = 8'(T_TOUT);

    state_t     state;
    state_t     nxt_state;
    logic [7:0] cnt;
    logic [7:0] nxt_cnt;
    logic       set_alarm;
    logic       last;

    // The counter holds the cycles left in the current phase, including this one.
    assign last = (cnt == 8'd1);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt - 8'd1;
        set_alarm = 1'b0;
        case (state)
            IDLE: begin
                nxt_cnt = 8'd0;
                if (start) begin
                    nxt_state = PC;
                    nxt_cnt   = LEN_PULSE;
                end
            end
            PC: begin
                if (last) begin
                    nxt_state = S1;
                    nxt_cnt   = LEN_PULSE;
                end
            end
            S1: begin
                if (last) begin
                    if (ekc_1) begin
                        nxt_state = KC;
                        nxt_cnt   = LEN_PULSE;
                    end else if (mem && !ok) begin
                        nxt_state = WAIT;
                        nxt_cnt   = LEN_TOUT;
                    end else begin
                        nxt_state = S2;
                        nxt_cnt   = LEN_PULSE;
                    end
                end
            end
            WAIT: begin
                if (ok || last) begin
                    nxt_state = S2;
                    nxt_cnt   = LEN_PULSE;
                    set_alarm = !ok;
                end
            end
            S2: begin
                if (last) begin
                    if (ekc_2) begin
                        nxt_state = KC;
                        nxt_cnt   = LEN_PULSE;
                    end else begin
                        nxt_state = GOT;
                        nxt_cnt   = LEN_GOT;
                    end
                end
            end
            GOT: begin
                if (last) begin
                    nxt_state = KC;
                    nxt_cnt   = LEN_PULSE;
                end
            end
            KC: begin
                if (last) begin
                    if (start) begin
                        nxt_state = PC;
                        nxt_cnt   = LEN_PULSE;
                    end else begin
                        nxt_state = IDLE;
                        nxt_cnt   = 8'd0;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 8'd0;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with phase.
    always_ff @(posedge clk) begin
        if (!clm_n) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            alarm  <= 1'b0;
            pc     <= 1'b0;
            strob1 <= 1'b0;
            strob2 <= 1'b0;
            got    <= 1'b0;
            kc     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            alarm  <= alarm | set_alarm;
            pc     <= (nxt_state == PC);
            strob1 <= (nxt_state == S1);
            strob2 <= (nxt_state == S2);
            got    <= (nxt_state == GOT);
            kc     <= (nxt_state == KC);
            busy   <= (nxt_state != IDLE);
        end
    end

    assign phase = state;

endmodule

`default_nettype wire

// File: tb/tb_strob_seq.sv
// tb_strob_seq: randomized and directed stimulus for strob_seq, checked every cycle
// against a phase/duration reference model.
`default_nettype none

module tb_strob_seq;

    localparam int TP = 2;
    localparam int TG = 1;
    localparam int TT = 64;

    logic       clk = 1'b0;
    logic       clm_n, start, ekc_1, ekc_2, mem, ok;
    logic       pc, strob1, strob2, got, kc, busy, alarm;
    logic [2:0] phase;

    strob_seq dut (
        .clk    (clk),
        .clm_n  (clm_n),
        .start  (start),
        .ekc_1  (ekc_1),
        .ekc_2  (ekc_2),
        .mem    (mem),
        .ok     (ok),
        .pc     (pc),
        .strob1 (strob1),
        .strob2 (strob2),
        .got    (got),
        .kc     (kc),
        .busy   (busy),
        .alarm  (alarm),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: current phase code, cycles already spent in it, sticky alarm.
    int m_ph    = 0;
    int m_el    = 0;
    bit m_alarm = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic enter(input int p);
        m_ph = p;
        m_el = 0;
    endtask

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (!clm_n) begin
            m_ph    = 0;
            m_el    = 0;
            m_alarm = 1'b0;
            return;
        end
        case (m_ph)
            0: if (start) enter(1);
            1: if (m_el + 1 == TP) enter(2); else m_el++;
            2: begin
                if (m_el + 1 == TP) begin
                    if (ekc_1)           enter(6);
                    else if (mem && !ok) enter(3);
                    else                 enter(4);
                end else m_el++;
            end
            3: begin
                if (ok) enter(4);
                else if (m_el + 1 == TT) begin
                    m_alarm = 1'b1;
                    enter(4);
                end else m_el++;
            end
            4: if (m_el + 1 == TP) enter(ekc_2 ? 6 : 5); else m_el++;
            5: if (m_el + 1 == TG) enter(6); else m_el++;
            6: if (m_el + 1 == TP) enter(start ? 1 : 0); else m_el++;
            default: enter(0);
        endcase
    endtask

    task automatic step(input logic s, input logic e1, input logic e2,
                        input logic m, input logic o, input logic rn);
        logic [6:0] exp_outs;
        start = s; ekc_1 = e1; ekc_2 = e2; mem = m; ok = o; clm_n = rn;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        exp_outs = {m_ph == 1, m_ph == 2, m_ph == 4, m_ph == 5, m_ph == 6, m_ph != 0, m_alarm};
        check("phase", 32'(phase), 32'(m_ph));
        check("outs", 32'({pc, strob1, strob2, got, kc, busy, alarm}), 32'(exp_outs));
    endtask

    initial begin
        int         last_rise;
        int         wrun;
        logic       prev_pc;

        start = 1'b1; ekc_1 = 1'b0; ekc_2 = 1'b0; mem = 1'b0; ok = 1'b0; clm_n = 1'b0;

        // Reset held with start asserted: must stay idle.
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Plain cycles: 9-cycle repeating period, no idle gap.
        last_rise = -1;
        prev_pc   = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step(1, 0, 0, 0, 0, 1);
            if (pc && !prev_pc) begin
                if (last_rise >= 0) check("period", 32'(cyc - last_rise), 32'd9);
                last_rise = cyc;
            end
            prev_pc = pc;
        end

        // Early end after STROB1, with and without a memory request.
        for (int i = 0; i < 30; i++)
            step(1, 1, $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1);

        // Memory never answers: WAIT times out after exactly T_TOUT cycles.
        wrun = 0;
        for (int i = 0; i < 150; i++) begin
            step(1, 0, 0, 1, 0, 1);
            if (phase == 3'd3) wrun++;
            else if (wrun > 0) begin
                check("wait_len", 32'(wrun), 32'(TT));
                wrun = 0;
            end
        end

        // Normal cycles afterwards keep the alarm set.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1);
        check("alarm_sticky", 32'(alarm), 32'd1);

        // Reset while waiting clears everything, alarm included.
        for (int i = 0; i < 20 && phase != 3'd3; i++) step(1, 0, 0, 1, 0, 1);
        check("reach_wait", 32'(phase), 32'd3);
        step(1, 0, 0, 1, 0, 0);
        check("alarm_clr", 32'(alarm), 32'd0);

        // Start dropped during STROB1: cycle finishes, then idle.
        for (int i = 0; i < 20 && phase != 3'd2; i++) step(1, 0, 0, 0, 0, 1);
        check("reach_s1", 32'(phase), 32'd2);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 1);
        check("idle_busy", 32'({busy, phase}), 32'd0);

        // Fully random traffic with occasional resets.
        for (int i = 0; i < 2500; i++)
            step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
                 1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 64) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
